jesd_tx_link_ctrl: RTL and testbench

Parametrised multi-lane JESD204B transmit link controller. It sequences the code-group-sync (K), initial-lane-alignment (ILA) and user-data phases for up to LANES lanes. It drives a per-lane 2-bit octet-source select into each lane's 8b/10b encoder mux. It adds a programmable K-length override, a lane-enable mask, an ILA multiframe index for configuration-data insertion, link status, and a saturating re-link counter.

---
 rtl/jesd_tx_link_ctrl.sv | 88 ++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd_tx_link_ctrl.sv
// jesd_tx_link_ctrl: JESD204B TX link sequencer (K -> ILA -> DATA) driving per-lane octet-source selects.
module jesd_tx_link_ctrl #(
    parameter int LANES    = 4,
    parameter int RELINK_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_clk,
    input  logic                  lmfc_clk,
    input  logic                  i_sync_request,
    input  logic [7:0]            i_F,
    input  logic [7:0]            i_ila_mf_len,
    input  logic [3:0]            i_kmin_override,
    input  logic [LANES-1:0]      i_lane_en,
    output logic [2*LANES-1:0]    o_link_mux,
    output logic [1:0]            o_state,
    output logic                  o_link_up,
    output logic                  o_ila_start,
    output logic [7:0]            o_ila_mf_idx,
    output logic [RELINK_W-1:0]   o_relink_cnt
);
    typedef enum logic [1:0] {SYNC = 2'd0, ILA = 2'd1, DATA = 2'd2} state_t;
    state_t state, state_nxt;
    logic [3:0] k_cnt, k_nxt, kmin;
    logic [7:0] mf_cnt, mf_nxt;
    logic [LANES-1:0] lane_en_q, lane_en_nxt, mask;
    logic [2*LANES-1:0] mux_nxt;
    logic [RELINK_W-1:0] relink_nxt;
    logic go_ila;
    assign kmin = i_kmin_override != 4'd0 ? i_kmin_override :
                  i_F == 8'd0 ? 4'd10 : i_F == 8'd1 ? 4'd6 : i_F < 8'd4 ? 4'd4 : i_F < 8'd8 ? 4'd3 : 4'd2;
    // k_cnt is compared before this cycle's frame_clk increment lands
    assign go_ila = state == SYNC && !i_sync_request && k_cnt >= kmin && lmfc_clk;
    always_comb begin
        state_nxt   = SYNC;
        k_nxt       = '0;
        mf_nxt      = '0;
        lane_en_nxt = lane_en_q;
        relink_nxt  = o_relink_cnt;
        mux_nxt     = '0;
        case (state)
            SYNC: begin
                k_nxt = (!i_sync_request && frame_clk && k_cnt != 4'hf) ? k_cnt + 4'd1 : k_cnt;
                if (go_ila) begin
                    state_nxt   = ILA;
                    lane_en_nxt = i_lane_en;
                end
            end
            ILA: if (!i_sync_request) begin
                if (lmfc_clk && mf_cnt == i_ila_mf_len) state_nxt = DATA;
                else begin
                    state_nxt = ILA;
                    mf_nxt    = mf_cnt + {7'd0, lmfc_clk};
                end
            end
            DATA: state_nxt = i_sync_request ? SYNC : DATA;
            default: ;
        endcase
        if ((state == ILA || state == DATA) && i_sync_request && ~&o_relink_cnt)
            relink_nxt = o_relink_cnt + 1'b1;
        mask = state_nxt == SYNC ? i_lane_en : lane_en_nxt;
        for (int n = 0; n < LANES; n++)
            mux_nxt[2*n +: 2] = !mask[n] ? 2'd3 : state_nxt == SYNC ? 2'd1 : state_nxt == ILA ? 2'd2 : 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SYNC;
            k_cnt        <= '0;
            mf_cnt       <= '0;
            lane_en_q    <= '1;
            o_link_mux   <= {LANES{2'b01}};
            o_link_up    <= 1'b0;
            o_ila_start  <= 1'b0;
            o_relink_cnt <= '0;
        end else begin
            state        <= state_nxt;
            k_cnt        <= k_nxt;
            mf_cnt       <= mf_nxt;
            lane_en_q    <= lane_en_nxt;
            o_link_mux   <= mux_nxt;
            o_link_up    <= state_nxt == DATA;
            o_ila_start  <= go_ila;
            o_relink_cnt <= relink_nxt;
        end
    end
    assign o_state      = state;
    assign o_ila_mf_idx = mf_cnt;
endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// tb_jesd_tx_link_ctrl: randomized link sequencing checked against a frame/multiframe counting model.
module tb_jesd_tx_link_ctrl;
    localparam int LANES = 4;
    localparam int RW    = 8;
    logic clk = 1'b0, rst_n = 1'b1, frame_clk = 1'b0, lmfc_clk = 1'b0, i_sync_request = 1'b0;
    logic [7:0] i_F = '0, i_ila_mf_len = '0;
    logic [3:0] i_kmin_override = '0;
    logic [LANES-1:0] i_lane_en = '1;
    logic [2*LANES-1:0] o_link_mux;
    logic [1:0] o_state;
    logic o_link_up, o_ila_start;
    logic [7:0] o_ila_mf_idx;
    logic [RW-1:0] o_relink_cnt;
    wire [27:0] obs = {o_link_mux, o_state, o_link_up, o_ila_start, o_ila_mf_idx, o_relink_cnt};
    logic [27:0] exp_v;
    int total = 0, bad = 0, cyc = 0;
    int m_phase, m_frames, m_mf, m_relink;
    logic [LANES-1:0] m_mask;
    bit m_start;

    jesd_tx_link_ctrl #(.LANES(LANES), .RELINK_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_clk(frame_clk), .lmfc_clk(lmfc_clk),
        .i_sync_request(i_sync_request), .i_F(i_F), .i_ila_mf_len(i_ila_mf_len),
        .i_kmin_override(i_kmin_override), .i_lane_en(i_lane_en), .o_link_mux(o_link_mux),
        .o_state(o_state), .o_link_up(o_link_up), .o_ila_start(o_ila_start),
        .o_ila_mf_idx(o_ila_mf_idx), .o_relink_cnt(o_relink_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_mf = 0; m_relink = 0; m_mask = '1; m_start = 0;
        exp_v = {{LANES{2'b01}}, 20'd0};
    endtask

    task automatic pulses(input int fp, input int lp);
        frame_clk = (cyc % fp) == 0;
        lmfc_clk  = (cyc % lp) == 0;
    endtask

    // phase: 0 = code-group sync, 1 = ILA, 2 = user data
    task automatic tick();
        int f, km;
        logic [LANES-1:0] e_mask;
        logic [2*LANES-1:0] e_mux;
        f  = int'(i_F) + 1;
        km = i_kmin_override != 0 ? int'(i_kmin_override) :
             f == 1 ? 10 : f == 2 ? 6 : f <= 4 ? 4 : f <= 8 ? 3 : 2;
        m_start = 0;
        if (m_phase == 0) begin
            if (!i_sync_request && m_frames >= km && lmfc_clk) begin
                m_phase = 1; m_mf = 0; m_mask = i_lane_en; m_start = 1;
            end else if (!i_sync_request && frame_clk && m_frames < 15) m_frames++;
        end else if (i_sync_request) begin
            m_phase = 0; m_frames = 0;
            if (m_relink < (1 << RW) - 1) m_relink++;
        end else if (m_phase == 1 && lmfc_clk) begin
            if (m_mf == int'(i_ila_mf_len)) m_phase = 2;
            else m_mf++;
        end
        e_mask = m_phase == 0 ? i_lane_en : m_mask;
        for (int n = 0; n < LANES; n++)
            e_mux[2*n +: 2] = !e_mask[n] ? 2'd3 : m_phase == 0 ? 2'd1 : m_phase == 1 ? 2'd2 : 2'd0;
        exp_v = {e_mux, 2'(m_phase), 1'(m_phase == 2), m_start, 8'(m_phase == 1 ? m_mf : 0), RW'(m_relink)};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_sync_request = 1'b0; frame_clk = 1'b0; lmfc_clk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #2;
        i_lane_en = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, exp_v); end
        @(posedge clk);
        #1;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, exp_v); end
        i_lane_en = '1;
    endtask

    task automatic test_f1_link();
        int fp, lp, max_idx, frames_drv, frames_at_ila, prev;
        do_reset();
        i_F = 8'd0; i_kmin_override = 4'd0; i_ila_mf_len = 8'd3; i_lane_en = '1;
        fp = int'($urandom_range(2, 4)); lp = int'($urandom_range(5, 9));
        max_idx = 0; frames_drv = 0; frames_at_ila = -1;
        for (int c = 0; c < 2000 && m_phase != 2; c++) begin
            pulses(fp, lp);
            prev = frames_drv;
            if (frame_clk) frames_drv++;
            tick();
            if (o_ila_start === 1'b1) frames_at_ila = prev;
            if (int'(o_ila_mf_idx) > max_idx) max_idx = int'(o_ila_mf_idx);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL f1_cycle cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        total++;
        if (o_link_up !== 1'b1 || o_link_mux !== '0) begin
            bad++; $display("FAIL f1_data up=%b mux=%h want up=1 mux=00", o_link_up, o_link_mux);
        end
        total++;
        if (frames_at_ila < 10) begin bad++; $display("FAIL f1_kmin frames=%0d want>=10", frames_at_ila); end
        total++;
        if (max_idx != 3) begin bad++; $display("FAIL f1_ila_idx max=%0d want=3", max_idx); end
    endtask

    task automatic test_override();
        int frames_drv, frames_at_ila, prev;
        do_reset();
        i_F = 8'd15; i_kmin_override = 4'd7; i_ila_mf_len = 8'd1; i_lane_en = '1;
        frames_drv = 0; frames_at_ila = -1;
        for (int c = 0; c < 500 && m_phase != 2; c++) begin
            pulses(2, 3);
            prev = frames_drv;
            if (frame_clk) frames_drv++;
            tick();
            if (o_ila_start === 1'b1) frames_at_ila = prev;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL ovr_cycle cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        total++;
        if (frames_at_ila < 7) begin bad++; $display("FAIL ovr_kmin frames=%0d want>=7", frames_at_ila); end
    endtask

    task automatic test_lane_mask();
        bit mux_ok;
        do_reset();
        i_F = 8'd3; i_kmin_override = 4'd0; i_ila_mf_len = 8'd1; i_lane_en = 4'b0101;
        for (int c = 0; c < 500 && m_phase != 2; c++) begin
            pulses(2, 5);
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mask_link cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        i_lane_en = 4'b1111;
        mux_ok = 1;
        for (int c = 0; c < 10; c++) begin
            pulses(2, 5);
            tick();
            if (o_link_mux !== 8'hcc) mux_ok = 0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mask_data cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        total++;
        if (!mux_ok) begin bad++; $display("FAIL mask_held mux=%h want=cc", o_link_mux); end
        i_sync_request = 1'b1;
        pulses(2, 5);
        tick();
        i_sync_request = 1'b0;
        total++;
        if (obs !== exp_v || o_link_mux !== 8'h55) begin
            bad++; $display("FAIL mask_resync got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_relink_sat();
        do_reset();
        i_F = 8'd7; i_kmin_override = 4'd1; i_ila_mf_len = 8'd0; i_lane_en = '1;
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 40 && m_phase != 2; c++) begin
                pulses(1, 2);
                tick();
                total++;
                if (obs !== exp_v) begin bad++; $display("FAIL sat_link p=%0d got=%h want=%h", p, obs, exp_v); end
            end
            i_sync_request = 1'b1;
            pulses(1, 2);
            tick();
            i_sync_request = 1'b0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL sat_req p=%0d got=%h want=%h", p, obs, exp_v); end
        end
        total++;
        if (o_relink_cnt !== 8'hff) begin bad++; $display("FAIL sat_final got=%0d want=255", o_relink_cnt); end
    endtask

    task automatic test_sync_last_lmfc();
        bit up_seen, hit;
        do_reset();
        i_F = 8'd0; i_kmin_override = 4'd2; i_ila_mf_len = 8'd2; i_lane_en = '1;
        up_seen = 0; hit = 0;
        for (int c = 0; c < 300 && !hit; c++) begin
            pulses(1, 4);
            if (m_phase == 1 && m_mf == 2 && lmfc_clk) begin i_sync_request = 1'b1; hit = 1; end
            tick();
            if (o_link_up === 1'b1) up_seen = 1;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL last_cycle cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        i_sync_request = 1'b0;
        total++;
        if (!hit || up_seen || o_state !== 2'd0 || o_relink_cnt !== 8'd1) begin
            bad++; $display("FAIL last_lmfc hit=%0d up_seen=%0d state=%0d relink=%0d want 1/0/0/1",
                            hit, up_seen, o_state, o_relink_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_F = 8'd1; i_kmin_override = 4'd0; i_ila_mf_len = 8'd5; i_lane_en = 4'b0011;
        for (int c = 0; c < 500 && !(m_phase == 1 && m_mf >= 2); c++) begin
            pulses(2, 3);
            tick();
        end
        total++;
        if (o_state !== 2'd1 || o_ila_mf_idx < 8'd2) begin
            bad++; $display("FAIL arst_setup state=%0d idx=%0d want 1/>=2", o_state, o_ila_mf_idx);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== {8'h55, 20'd0}) begin bad++; $display("FAIL arst_mid_ila got=%h want=%h", obs, {8'h55, 20'd0}); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_lane_en = '1;
    endtask

    task automatic test_random();
        int fp, lp, hold;
        do_reset();
        i_F = 8'd2; i_kmin_override = 4'd0; i_ila_mf_len = 8'd2; i_lane_en = '1;
        fp = int'($urandom_range(2, 4)); lp = int'($urandom_range(5, 12)); hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_phase == 0 && $urandom_range(0, 30) == 0) begin
                i_F = 8'($urandom_range(0, 15));
                i_ila_mf_len = 8'($urandom_range(0, 3));
                i_kmin_override = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
            end
            if (hold == 0 && $urandom_range(0, 80) == 0) hold = int'($urandom_range(1, 4));
            i_sync_request = hold > 0;
            if (hold > 0) hold--;
            if ($urandom_range(0, 20) == 0) i_lane_en = 4'($urandom);
            pulses(fp, lp);
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", cyc, obs, exp_v); end
        end
        i_sync_request = 1'b0;
    endtask

    initial begin
        test_reset();
        test_f1_link();
        test_override();
        test_lane_mask();
        test_relink_sat();
        test_sync_last_lmfc();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
